fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction prefetch stage between the PC/instruction-memory front end and the IF/ID pipeline register. It issues sequential fetches to a one-cycle-latency instruction memory and buffers returned instruction/PC pairs in a small FIFO. It presents the head entry to the decode side. Branch redirects flush the buffer, and decode stalls hold the head without stopping prefetch until the buffer is full.

## Interface
- PC_W, 9, program-counter / instruction-memory address width
- INS_W, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- redirect  in  1  branch taken in EX; flush and refetch
- redirect_pc  in  PC_W  redirect target; bits [1:0] ignored (forced 0)
- stall  in  1  decode hazard stall; head must not be consumed
- imem_req  out  1  fetch request this cycle
- imem_addr  out  PC_W  fetch address, word aligned
- imem_rdata  in  INS_W  instruction for the request issued in the previous cycle
- out_valid  out  1  head entry valid
- out_pc  out  PC_W  PC of head entry; 0 when empty
- out_instr  out  INS_W  head instruction; 0 (bubble) when empty
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- State: fetch_pc, inflight flag, inflight_pc, FIFO (head/tail pointers, count).
- Issue condition: !redirect && (count + inflight) < DEPTH. On issue: imem_req=1, imem_addr=fetch_pc, inflight←1, inflight_pc←fetch_pc, fetch_pc←fetch_pc+4 mod 2^PC_W. Otherwise: imem_req=0, inflight←0.
- Response: when inflight=1 and no redirect this cycle, {inflight_pc, imem_rdata} is enqueued at the tail. The credit rule guarantees that the FIFO is never full at enqueue.
- Dequeue: deq = out_valid && !stall && !redirect. Head pointer advances and count decrements.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Redirect has priority over everything:
  - count←0 and pointers←0.
  - An inflight response arriving in the redirect cycle is discarded, and inflight←0.
  - fetch_pc←{redirect_pc[PC_W-1:2],2'b00}.
  - No request is issued in the redirect cycle.
- stall with redirect asserted: redirect wins.
- Outputs out_pc/out_instr/out_valid come combinationally from the head register, with no input-to-output path. out_valid = (count≠0).
- imem_req/imem_addr are combinational from fetch_pc, count, inflight and redirect.
- Reset: fetch_pc=0, inflight=0, count=0, pointers=0, and FIFO contents are don't-care. In the reset cycle imem_req=0, out_valid=0, out_pc=0, out_instr=0 and count=0. Reset asserted mid-operation discards all entries and any inflight response.

## Timing
- Request to enqueue: a request issued in cycle t returns data in t+1, which is written at the end of t+1. out_valid rises in t+2.
- After reset deasserts in cycle 0, the first request is at PC 0 in cycle 0, and out_valid=1 with out_pc=0 in cycle 2.
- Redirect in cycle t: first request at the target in t+1, target visible at the head in t+3. The datapath sees 3 bubble cycles.
- Steady state with no stall gives one instruction per cycle, with count at 1 and inflight at 1.
- Sustained stall: the buffer fills to DEPTH and imem_req stays 0 until a dequeue frees credit. The first request after release comes in the cycle after the dequeue.
- PC wrap: fetch_pc at 2^PC_W−4 is followed by 0, with no special handling.

## Structure
- The shared pipeline package holds:
  - the NOP/bubble constant (32'h0);
  - the fetch-entry struct {pc[PC_W-1:0], instr[INS_W-1:0]};
  - the PC increment constant (4).
- One sub-module, fetch_fifo: a synchronous FIFO of fetch-entry structs with enq, deq, flush, count, and a head output. It holds pointer/count logic only; all credit and redirect policy stays in fetch_buffer.

## Test plan
- Reset then free-run, no stall: the following values are required.
  - imem_addr = 0,4,8,… on consecutive cycles.
  - out_pc = 0,4,8,… starting in cycle 2.
  - out_instr equals the memory word at each PC.
- stall held high for 10 cycles from cycle 3:
  - count saturates at 4 and imem_req drops to 0.
  - The head stays at PC 4 throughout.
  - After release, out_pc continues 4,8,12,… with no gaps or duplicates.
- redirect=1 with redirect_pc=9'h0A3 while an inflight request for PC 0x10 is pending:
  - The 0x10 response is dropped and count=0 next cycle.
  - The next imem_addr is 0xA0, and out_pc=0xA0 appears 3 cycles after the redirect.
- redirect and stall asserted together while full: the flush occurs, count=0 and no dequeue is recorded.
- Wrap with PC_W=9: fetching from 0x1F8 gives the sequence 0x1F8, 0x1FC, 0x000, 0x004 on both imem_addr and out_pc.
- reset pulsed for one cycle mid-stream with count=3: in the next cycle out_valid=0, count=0 and imem_req=1 at addr 0. No stale entries ever appear.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
// Shared fetch-pipeline definitions.
//   FB_PC_W / FB_INS_W : default PC and instruction widths
//   NOP_INSTR          : bubble word presented to decode when the buffer is empty
//   PC_INC             : sequential fetch stride in bytes
//   fetch_entry_t      : one buffered {pc, instr} pair
package fetch_buffer_pkg;

    localparam int FB_PC_W  = 9;
    localparam int FB_INS_W = 32;

    localparam logic [FB_INS_W-1:0] NOP_INSTR = 32'h0;
    localparam int PC_INC = 4;

    typedef struct packed {
        logic [FB_PC_W-1:0]  pc;
        logic [FB_INS_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries. Pure storage: pointer and count
// bookkeeping only; the caller decides when enq/deq/flush are legal.
//   clk, reset : clock, synchronous active-high reset
//   flush      : clear pointers and count (contents left as-is)
//   enq        : write enq_data at the tail
//   deq        : advance the head
//   head       : entry at the head pointer (meaningful only when count != 0)
//   count      : occupied entries
module fetch_fifo
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               enq,
    input  fetch_entry_t       enq_data,
    input  logic               deq,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Storage needs no reset; a stale write is harmless because the
    // pointers are cleared in the same cycle.
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= enq_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer between the PC/imem front end and IF/ID.
// Issues sequential fetches to a one-cycle-latency instruction memory,
// buffers returned {pc, instr} pairs, and presents the head to decode.
//   clk, reset          : clock, synchronous active-high reset
//   redirect/redirect_pc: branch taken in EX; flush and refetch at target
//   stall               : decode hazard; hold the head entry
//   imem_req/imem_addr  : fetch request issued this cycle
//   imem_rdata          : data for last cycle's request
//   out_valid/pc/instr  : head entry (pc/instr are 0 when empty)
//   count               : occupied entries
// The entry struct carries the package widths, so PC_W/INS_W stay at
// their package defaults.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int PC_W  = FB_PC_W,
    parameter int INS_W = FB_INS_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    input  logic                     stall,
    output logic                     imem_req,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [INS_W-1:0]         imem_rdata,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [INS_W-1:0]         out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] fetch_pc;
    logic            inflight;
    logic [PC_W-1:0] inflight_pc;
    logic [CNT_W:0]  pending;
    logic            issue;
    logic            enq;
    logic            deq;
    fetch_entry_t    enq_data;
    fetch_entry_t    head;

    // Credit: buffered entries plus the one response in flight must leave
    // room, so an arriving response always finds a free slot.
    assign pending = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign issue   = !reset && !redirect && (pending < (CNT_W+1)'(DEPTH));

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    assign enq            = inflight && !redirect;
    assign deq            = out_valid && !stall && !redirect;
    assign enq_data.pc    = inflight_pc;
    assign enq_data.instr = imem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= '0;
            inflight <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) fetch_pc <= fetch_pc + PC_W'(PC_INC);
        end
    end

    always_ff @(posedge clk) begin
        if (issue) inflight_pc <= fetch_pc;
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect),
        .enq      (enq),
        .enq_data (enq_data),
        .deq      (deq),
        .head     (head),
        .count    (count)
    );

    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? head.pc    : '0;
    assign out_instr = out_valid ? head.instr : NOP_INSTR;

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [8:0]  redirect_pc = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic [8:0]  out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Memory contents: a tag in the top byte plus the word's own address.
    function automatic logic [31:0] word(input logic [8:0] a);
        return {8'hE7, 15'h0, a};
    endfunction

    // One-cycle-latency instruction memory.
    always @(posedge clk) imem_rdata <= word(imem_addr);

    // Inputs change 1 time unit after the rising edge; outputs are read on
    // the falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 (first cycle with reset low).
    task automatic do_reset();
        reset = 1'b1; redirect = 1'b0; stall = 1'b0; redirect_pc = '0;
        nxt();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        nxt();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0 || out_valid !== 1'b0 || out_pc !== 9'h0 ||
                out_instr !== 32'h0 || count !== 3'd0) begin
                errors++;
                $display("FAIL reset_state got req=%b valid=%b pc=%h instr=%h count=%0d want all zero",
                         imem_req, out_valid, out_pc, out_instr, count);
            end
            nxt();
        end
    endtask

    task automatic test_free_run();
        logic [8:0] exp;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp = 9'(4 * c);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp) begin
                errors++;
                $display("FAIL free_run_req c=%0d got req=%b addr=%h want req=1 addr=%h",
                         c, imem_req, imem_addr, exp);
            end
            checks++;
            if (c >= 2) begin
                exp = 9'(4 * (c - 2));
                if (out_valid !== 1'b1 || out_pc !== exp || out_instr !== word(exp) || count !== 3'd1) begin
                    errors++;
                    $display("FAIL free_run_head c=%0d got v=%b pc=%h instr=%h cnt=%0d want v=1 pc=%h instr=%h cnt=1",
                             c, out_valid, out_pc, out_instr, count, exp, word(exp));
                end
            end else if (out_valid !== 1'b0 || out_pc !== 9'h0 || out_instr !== 32'h0) begin
                errors++;
                $display("FAIL free_run_empty c=%0d got v=%b pc=%h instr=%h want 0 0 0",
                         c, out_valid, out_pc, out_instr);
            end
            nxt();
        end
    endtask

    task automatic test_stall();
        logic [8:0] exp;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            stall = (c >= 3 && c <= 12);
            @(negedge clk);
            if (c >= 6 && c <= 13) begin
                checks++;
                if (count !== 3'd4) begin
                    errors++;
                    $display("FAIL stall_full c=%0d got count=%0d want 4", c, count);
                end
            end
            if (c >= 5 && c <= 13) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_noreq c=%0d got req=%b want 0", c, imem_req);
                end
            end
            if (c == 14) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 9'h014) begin
                    errors++;
                    $display("FAIL stall_resume_req got req=%b addr=%h want req=1 addr=014",
                             imem_req, imem_addr);
                end
            end
            if (c >= 3) begin
                exp = (c <= 13) ? 9'h004 : 9'(4 * (c - 12));
                checks++;
                if (out_valid !== 1'b1 || out_pc !== exp || out_instr !== word(exp)) begin
                    errors++;
                    $display("FAIL stall_head c=%0d got v=%b pc=%h instr=%h want v=1 pc=%h",
                             c, out_valid, out_pc, out_instr, exp);
                end
            end
            nxt();
        end
        stall = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset();
        for (int c = 0; c < 5; c++) nxt();
        // Cycle 5: response for PC 0x10 is arriving.
        redirect = 1'b1; redirect_pc = 9'h0A3;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redirect_noreq got req=%b want 0", imem_req);
        end
        nxt();
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 9'h0A0) begin
            errors++;
            $display("FAIL redirect_flush got cnt=%0d v=%b req=%b addr=%h want cnt=0 v=0 req=1 addr=0a0",
                     count, out_valid, imem_req, imem_addr);
        end
        nxt();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 9'h0A4) begin
            errors++;
            $display("FAIL redirect_bubble got v=%b addr=%h want v=0 addr=0a4", out_valid, imem_addr);
        end
        nxt();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 9'h0A0 || out_instr !== word(9'h0A0)) begin
            errors++;
            $display("FAIL redirect_target got v=%b pc=%h instr=%h want v=1 pc=0a0 instr=%h",
                     out_valid, out_pc, out_instr, word(9'h0A0));
        end
        nxt();
        @(negedge clk);
        checks++;
        if (out_pc !== 9'h0A4) begin
            errors++;
            $display("FAIL redirect_next got pc=%h want 0a4", out_pc);
        end
        nxt();
    endtask

    task automatic test_redirect_stall_full();
        do_reset();
        stall = 1'b1;
        for (int c = 0; c < 8; c++) nxt();
        @(negedge clk);
        checks++;
        if (count !== 3'd4 || out_pc !== 9'h000) begin
            errors++;
            $display("FAIL rs_prefill got cnt=%0d pc=%h want cnt=4 pc=000", count, out_pc);
        end
        nxt();
        redirect = 1'b1; redirect_pc = 9'h040;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rs_noreq got req=%b want 0", imem_req);
        end
        nxt();
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 9'h040) begin
            errors++;
            $display("FAIL rs_flush got cnt=%0d v=%b req=%b addr=%h want cnt=0 v=0 req=1 addr=040",
                     count, out_valid, imem_req, imem_addr);
        end
        nxt();
        nxt();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 9'h040 || count !== 3'd1) begin
            errors++;
            $display("FAIL rs_target got v=%b pc=%h cnt=%0d want v=1 pc=040 cnt=1", out_valid, out_pc, count);
        end
        nxt();
        @(negedge clk);
        checks++;
        if (out_pc !== 9'h040 || count !== 3'd2) begin
            errors++;
            $display("FAIL rs_hold got pc=%h cnt=%0d want pc=040 cnt=2", out_pc, count);
        end
        nxt();
        stall = 1'b0;
    endtask

    task automatic test_wrap();
        logic [8:0] seq [4];
        seq[0] = 9'h1F8; seq[1] = 9'h1FC; seq[2] = 9'h000; seq[3] = 9'h004;
        do_reset();
        redirect = 1'b1; redirect_pc = 9'h1F8;
        nxt();
        redirect = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 4) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== seq[k]) begin
                    errors++;
                    $display("FAIL wrap_addr k=%0d got req=%b addr=%h want req=1 addr=%h",
                             k, imem_req, imem_addr, seq[k]);
                end
            end
            if (k >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== seq[k-2] || out_instr !== word(seq[k-2])) begin
                    errors++;
                    $display("FAIL wrap_head k=%0d got v=%b pc=%h want v=1 pc=%h",
                             k, out_valid, out_pc, seq[k-2]);
                end
            end
            nxt();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        stall = 1'b1;
        for (int c = 0; c < 4; c++) nxt();
        @(negedge clk);
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL rm_prefill got cnt=%0d want 3", count);
        end
        nxt();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rm_reset_noreq got req=%b want 0", imem_req);
        end
        nxt();
        reset = 1'b0; stall = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 9'h000) begin
            errors++;
            $display("FAIL rm_after got v=%b cnt=%0d req=%b addr=%h want v=0 cnt=0 req=1 addr=000",
                     out_valid, count, imem_req, imem_addr);
        end
        nxt();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 9'h000) begin
            errors++;
            $display("FAIL rm_bubble got v=%b pc=%h want v=0 pc=000", out_valid, out_pc);
        end
        nxt();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 9'(4 * k) || out_instr !== word(9'(4 * k))) begin
                errors++;
                $display("FAIL rm_restart k=%0d got v=%b pc=%h want v=1 pc=%h", k, out_valid, out_pc, 9'(4 * k));
            end
            nxt();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall_full();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
